// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - core request/response and RAM word-port bundle for dmem_lsu
// master: core + RAM side; slave: the load/store unit.
interface dmem_lsu_if #(parameter int ADDR_W = 10);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] address;
   logic [31:0]       write_data;
   logic [31:0]       read_data;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  MemRead, MemWrite, address, write_data
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output MemRead, MemWrite, address, write_data
   );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-addressed load/store unit over a word RAM with read-modify-write
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses error out instead of being aligned down.
module dmem_lsu #(
   parameter int ADDR_W = 10
) (
   input  logic         CLK,
   input  logic         RSTn,
   dmem_lsu_if.slave    bus
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t            state, next;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        lo_q;
   logic [ADDR_W-1:0] word_q;
   logic [31:0]       wd_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [2:0]        f3;
   logic              illegal;
   logic              req_err;
   logic [1:0]        lo_in;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_ext;
   logic [31:0]       merged;
   logic              accept;
   logic              unused_addr;

   assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

   // Request decode; low address bits of half/word accesses are aligned down.
   always_comb begin
      f3      = bus.req_funct3;
      illegal = bus.req_we ? (f3[2] || f3[1:0] == 2'b11)
                           : (f3[1:0] == 2'b11 || f3 == 3'b110);
      case (f3[1:0])
         2'b01:   lo_in = {bus.req_addr[1], 1'b0};
         2'b10:   lo_in = 2'b00;
         default: lo_in = bus.req_addr[1:0];
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      req_err = illegal ||
                (f3[1:0] == 2'b01 && bus.req_addr[0]) ||
                (f3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
      req_err = illegal;
`endif
   end

   always_comb begin
      byte_sel = bus.read_data[{lo_q, 3'b000} +: 8];
      half_sel = lo_q[1] ? bus.read_data[31:16] : bus.read_data[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = bus.read_data;
      endcase
      merged = bus.read_data;
      case (f3_q[1:0])
         2'b00: merged[{lo_q, 3'b000} +: 8] = wd_q[7:0];
         2'b01: begin
            if (lo_q[1]) merged[31:16] = wd_q[15:0];
            else         merged[15:0]  = wd_q[15:0];
         end
         default: merged = wd_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next          = state;
      bus.req_ready = 1'b0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (req_err)                            next = RESP;
               else if (bus.req_we && f3 == 3'b010)    next = WR;
               else                                    next = RD;
            end
         end
         RD: begin
            bus.MemRead = 1'b1;
            next        = CAP;
         end
         CAP:     next = we_q ? WR : RESP;
         WR: begin
            bus.MemWrite = 1'b1;
            next         = RESP;
         end
         RESP:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         lo_q    <= 2'd0;
         word_q  <= '0;
         wd_q    <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q   <= bus.req_we;
            f3_q   <= f3;
            lo_q   <= lo_in;
            word_q <= bus.req_addr[ADDR_W+1:2];
            wd_q   <= bus.req_wdata;
            err_q  <= req_err;
         end
         if (state == CAP && we_q)
            wd_q <= merged;
         // Only a successful load leaves data behind; stores and errors report zero.
         if (next == RESP)
            rdata_q <= (state == CAP && !we_q) ? load_ext : 32'd0;
      end
   end

   assign bus.address    = word_q;
   assign bus.write_data = (state == WR) ? wd_q : 32'd0;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_err   = (state == RESP) && err_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard bench for dmem_lsu against a behavioural word RAM
// Expectations are pushed at request acceptance and popped on each resp_valid pulse.
module tb_dmem_lsu;

   localparam int ADDR_W = 10;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t sb[$];
   logic [31:0] mem [0:(1<<ADDR_W)-1];

   int          wr_cyc = -1, rd_cyc = -1, wr_cnt = 0, rd_cnt = 0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] wr_addr = 32'd0;

   dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_lsu #(.ADDR_W(ADDR_W)) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.MemRead)  bus.read_data <= mem[bus.address];
      if (bus.MemWrite) mem[bus.address] <= bus.write_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.MemRead || bus.MemWrite)
         check("strobe_excl", {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
      if (bus.MemRead) begin
         rd_cyc = cyc;
         rd_cnt++;
      end
      if (bus.MemWrite) begin
         wr_cyc  = cyc;
         wr_cnt++;
         wr_data = bus.write_data;
         wr_addr = {{(32-ADDR_W){1'b0}}, bus.address};
      end
      if (bus.resp_valid) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            check("resp_cycle", cyc, e.due);
         end
      end
   end

   // Issue one request; t_acc is the accept edge so spec offsets T+k map to t_acc+k.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input bit hold,
                        output int t_acc);
      exp_t e;
      int   n;
      @(negedge clk);
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      t_acc   = cyc - 1;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = t_acc + lat;
      sb.push_back(e);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_valid = hold;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         #1;
         if (sb.size() != 0 && hold) begin
            check("busy_ready", {31'd0, bus.req_ready}, 32'd0);
            bus.req_addr = $urandom;
         end
         n++;
      end
      bus.req_valid = 1'b0;
      if (sb.size() != 0) begin
         check("resp_timeout", 32'd1, 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int t;
      int rdc, wrc;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
      bus.read_data  = 32'd0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_memread", {31'd0, bus.MemRead}, 32'd0);
      check("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
      check("rst_address", {22'd0, bus.address}, 32'd0);
      check("rst_write_data", bus.write_data, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b0, t);
      check("sw_wr_cycle", wr_cyc, t + 1);
      check("sw_wr_addr", wr_addr, 32'd4);
      check("sw_wr_data", wr_data, 32'hDEADBEEF);

      issue(1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b100, 32'h13, 32'd0, 32'h000000DE, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b001, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b101, 32'h12, 32'd0, 32'h0000DEAD, 1'b0, 3, 1'b0, t);

      issue(1'b1, 3'b000, 32'h11, 32'h00000055, 32'd0, 1'b0, 4, 1'b0, t);
      check("sb_rd_cycle", rd_cyc, t + 1);
      check("sb_wr_cycle", wr_cyc, t + 3);
      check("sb_wr_data", wr_data, 32'hDEAD55EF);
      issue(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0, 3, 1'b0, t);

      rdc = rd_cnt;
      wrc = wr_cnt;
      issue(1'b1, 3'b011, 32'h10, 32'h12345678, 32'd0, 1'b1, 1, 1'b0, t);
      issue(1'b0, 3'b111, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b0, t);
      check("err_no_read", rd_cnt, rdc);
      check("err_no_write", wr_cnt, wrc);

`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, 1, 1'b0, t);
      issue(1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'd0, 1'b1, 1, 1'b0, t);
`else
      issue(1'b0, 3'b010, 32'h12, 32'd0, 32'hDEAD55EF, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b101, 32'h13, 32'd0, 32'h0000DEAD, 1'b0, 3, 1'b0, t);
`endif

      issue(1'b1, 3'b010, 32'h1000, 32'h12345678, 32'd0, 1'b0, 2, 1'b0, t);
      check("wrap_wr_addr", wr_addr, 32'd0);
      issue(1'b0, 3'b010, 32'h0, 32'd0, 32'h12345678, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b100, 32'h2, 32'd0, 32'h00000034, 1'b0, 3, 1'b0, t);
      issue(1'b1, 3'b001, 32'h1006, 32'h9999ABCD, 32'd0, 1'b0, 4, 1'b0, t);
      issue(1'b0, 3'b010, 32'h4, 32'd0, 32'hABCD0000, 1'b0, 3, 1'b0, t);
      issue(1'b0, 3'b001, 32'h6, 32'd0, 32'hFFFFABCD, 1'b0, 3, 1'b0, t);

      issue(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0, 3, 1'b1, t);
      issue(1'b1, 3'b000, 32'h12, 32'h000000A5, 32'd0, 1'b0, 4, 1'b1, t);
      issue(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEA555EF, 1'b0, 3, 1'b0, t);

      // Reset during CAP of a load: no response, outputs at reset values at once.
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h10;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_rd", {31'd0, bus.MemRead}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_mid_memread", {31'd0, bus.MemRead}, 32'd0);
      check("rst_mid_resp", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_mid_address", {22'd0, bus.address}, 32'd0);
      check("rst_mid_rdata", bus.resp_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_after_ready", {31'd0, bus.req_ready}, 32'd1);

      issue(1'b0, 3'b000, 32'h12, 32'd0, 32'hFFFFFFA5, 1'b0, 3, 1'b0, t);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
